// File: rtl/rf_wb_arbiter_if.sv
// Bundle of writeback, multi-cycle result, decode-check and register-file write signals.
// The arbiter takes the slave view; whatever drives the arbiter takes the master view.
interface rf_wb_arbiter_if;
   logic        a_wen;
   logic [4:0]  a_rw;
   logic [31:0] a_data;
   logic        a_stall;
   logic        b_valid;
   logic        b_ready;
   logic [4:0]  b_rw;
   logic [31:0] b_data;
   logic        issue_en;
   logic [4:0]  issue_rd;
   logic [4:0]  chk_ra;
   logic [4:0]  chk_rb;
   logic        hazard;
   logic        rf_wen;
   logic [4:0]  rf_rw;
   logic [31:0] rf_wdata;

   modport slave (
      input  a_wen, a_rw, a_data, b_valid, b_rw, b_data, issue_en, issue_rd, chk_ra, chk_rb,
      output a_stall, b_ready, hazard, rf_wen, rf_rw, rf_wdata
   );

   modport master (
      output a_wen, a_rw, a_data, b_valid, b_rw, b_data, issue_en, issue_rd, chk_ra, chk_rb,
      input  a_stall, b_ready, hazard, rf_wen, rf_rw, rf_wdata
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between core writeback (A) and FIFO-buffered
// multi-cycle results (B), bounds A's starvation of B, and tracks pending B destinations.
module rf_wb_arbiter #(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic           clk,
   input  logic           rst,
   rf_wb_arbiter_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [4:0]    fifo_rw_q   [DEPTH];
   logic [31:0]   fifo_data_q [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [31:0]   pending_q, pending_d;
   logic          push_s, pop_s, empty_s, starved_s;
   logic [4:0]    head_rw_s;
   logic [31:0]   head_data_s;

   assign head_rw_s   = fifo_rw_q[rd_ptr_q];
   assign head_data_s = fifo_data_q[rd_ptr_q];
   assign bus.b_ready = (count_q != CW'(DEPTH));
   assign bus.hazard  = pending_q[bus.chk_ra] | pending_q[bus.chk_rb];

   // Write-port arbitration: A wins unless it is idle or B has lost STARVE_MAX times in a row
   always_comb begin
      empty_s      = (count_q == {CW{1'b0}});
      starved_s    = (starve_q >= SW'(STARVE_MAX));
      push_s       = bus.b_valid & bus.b_ready & (bus.b_rw != 5'd0);
      pop_s        = 1'b0;
      bus.a_stall  = 1'b0;
      bus.rf_wen   = 1'b0;
      bus.rf_rw    = 5'd0;
      bus.rf_wdata = 32'd0;
      starve_d     = starve_q;
      if (!rst) begin
         starve_d = {SW{1'b0}};
      end else if (empty_s) begin
         starve_d = {SW{1'b0}};
         if (bus.a_wen) begin
            bus.rf_wen   = 1'b1;
            bus.rf_rw    = bus.a_rw;
            bus.rf_wdata = bus.a_data;
         end else begin
            bus.rf_wen   = 1'b0;
         end
      end else if (!bus.a_wen || starved_s) begin
         pop_s        = 1'b1;
         bus.a_stall  = bus.a_wen;
         bus.rf_wen   = 1'b1;
         bus.rf_rw    = head_rw_s;
         bus.rf_wdata = head_data_s;
         starve_d     = {SW{1'b0}};
      end else begin
         bus.rf_wen   = 1'b1;
         bus.rf_rw    = bus.a_rw;
         bus.rf_wdata = bus.a_data;
         starve_d     = starve_q + SW'(1);
      end
   end

   // FIFO bookkeeping and pending scoreboard; a same-cycle issue overrides the pop's clear
   always_comb begin
      wr_ptr_d  = wr_ptr_q + AW'(push_s);
      rd_ptr_d  = rd_ptr_q + AW'(pop_s);
      count_d   = count_q + CW'(push_s) - CW'(pop_s);
      pending_d = pending_q;
      if (pop_s) begin
         pending_d[head_rw_s] = 1'b0;
      end else begin
         pending_d = pending_q;
      end
      if (bus.issue_en && (bus.issue_rd != 5'd0)) begin
         pending_d[bus.issue_rd] = 1'b1;
      end else begin
         pending_d = pending_d;
      end
      pending_d[0] = 1'b0;
   end

   // State registers and FIFO storage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q  <= {AW{1'b0}};
         wr_ptr_q  <= {AW{1'b0}};
         count_q   <= {CW{1'b0}};
         starve_q  <= {SW{1'b0}};
         pending_q <= 32'd0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_rw_q[i]   <= 5'd0;
            fifo_data_q[i] <= 32'd0;
         end
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         starve_q  <= starve_d;
         pending_q <= pending_d;
         if (push_s) begin
            fifo_rw_q[wr_ptr_q]   <= bus.b_rw;
            fifo_data_q[wr_ptr_q] <= bus.b_data;
         end
      end
   end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and scoreboard for the 32x32 register file. It shares the file's single write port between the core's single-cycle writeback (port A) and a multi-cycle unit such as mul/div (port B). B results are buffered in a small FIFO, and A starvation of B is bounded. A per-register pending scoreboard tells decode which source registers still await a B result. It sits between the writeback stage, the multi-cycle unit and the register file's write inputs.

## Interface
- DEPTH, 2: B result FIFO entries (power of two, >=2)
- STARVE_MAX, 4: consecutive lost arbitration cycles after which B is forced through

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- a_wen  in  1  core writeback valid this cycle
- a_rw  in  5  core destination register
- a_data  in  32  core writeback data
- a_stall  out  1  A not written this cycle; core holds a_* and retries next cycle
- b_valid  in  1  B result offered
- b_ready  out  1  FIFO can accept; transfer on b_valid && b_ready
- b_rw  in  5  B destination register
- b_data  in  32  B result data
- issue_en  in  1  multi-cycle op issued this cycle
- issue_rd  in  5  its destination register
- chk_ra, chk_rb  in  5 each  decode source registers
- hazard  out  1  pending[chk_ra] or pending[chk_rb] (r0 never pending)
- rf_wen  out  1  to register file write enable
- rf_rw  out  5  to register file write address
- rf_wdata  out  32  to register file write data

## Operation
- State: FIFO (DEPTH x {5b reg, 32b data}, rd/wr pointers, count); pending[31:1]; starve_cnt (wide enough for STARVE_MAX).
- b_ready = (count != DEPTH), from registered count only. It does not depend on a same-cycle pop.
- Accepted B results with b_rw==0 are dropped and not enqueued.
- Arbitration is combinational each cycle:
  - FIFO empty: rf_* = A (rf_wen = a_wen); a_stall=0.
  - FIFO nonempty, a_wen=0: rf_* = head, pop; starve_cnt <= 0.
  - FIFO nonempty, a_wen=1, starve_cnt < STARVE_MAX: rf_* = A; starve_cnt++.
  - FIFO nonempty, a_wen=1, starve_cnt == STARVE_MAX: rf_* = head, pop, a_stall=1; starve_cnt <= 0.
- rf_wen=0 cycles drive rf_rw=0 and rf_wdata=0.
- Scoreboard:
  - issue_en && issue_rd!=0 sets pending[issue_rd].
  - A pop clears pending[head reg].
  - A set and a clear of the same register in the same cycle: set wins.
- hazard is combinational from registered pending. It stays 1 in the cycle the head is written, and drops the following cycle, when the write is visible on the file's read ports.
- Core obligations, not checked in hardware:
  - No issue to a register already pending.
  - No A write to a pending register.
  - a_* held stable while a_stall=1.

## Timing
- Reset (rst=0, any time): FIFO empty, pending=0, starve_cnt=0.
  - Outputs: b_ready=1, rf_wen=0, a_stall=0, hazard=0.
  - In-flight B results are discarded; the multi-cycle unit is reset with this block.
- A latency 0: a_* is visible on rf_* the same cycle and written at that clock edge.
- B latency: minimum 1 cycle. Accepted at edge N, written at edge N+1 if A is idle.
- Worst-case B head wait under continuous A: STARVE_MAX+1 cycles. A sees at most one stall per STARVE_MAX+1 cycles.
- Full FIFO with simultaneous pop: b_ready=0 that cycle; it reasserts the next cycle.
- Pointer wrap is modulo DEPTH.

## Test plan
- Reset mid-traffic (FIFO holding 2 entries, pending[5]=1), rst low 1 cycle:
  - Required: rf_wen=0, b_ready=1, hazard=0 immediately; FIFO drains nothing afterwards.
- Only A: a_wen=1, a_rw=3, a_data=0x12345678 for 1 cycle:
  - Required: rf_wen=1, rf_rw=3, rf_wdata=0x12345678 same cycle; a_stall=0.
- B with A idle:
  - Stimulus: issue_en, issue_rd=7; then b_valid, b_rw=7, b_data=0xDEADBEEF.
  - Required: hazard=1 for chk_ra=7; write to r7 one cycle after acceptance; hazard=0 the next cycle.
- Starvation: FIFO holds one entry for r9, a_wen=1 continuously, STARVE_MAX=4:
  - Required: A is written 4 cycles; cycle 5 writes r9 with a_stall=1; cycle 6 writes the held A.
- Full FIFO: DEPTH=2, two accepts while a_wen=1:
  - Required: b_ready=0; a third b_valid is not accepted until a pop plus one cycle.
  - Entries drain in order; wrap is exercised with 5 sequential results.
- r0 cases: b_rw=0 accepted, no rf_wen; issue_rd=0 never sets hazard.
